// File: rtl/seg_scan_capture_if.sv
// rtl/seg_scan_capture_if.sv - display-bus monitor signals for seg_scan_capture
//
// Groups the scanned display bus (inputs to the capture block) and the
// captured snapshot / status outputs.
//   master: scan-driver side, drives seg_sel/seg_ment, observes results
//   slave : capture block, observes the bus, drives results
//   seg_sel[5:0]      digit select, one-hot-low
//   seg_ment[6:0]     segments, active-low, bit6=a .. bit0=g
//   snap_digits[23:0] {pos5..pos0} BCD snapshot of the last complete frame
//   frame_done        one-cycle pulse on snapshot update
//   range_err         snapshot is not a legal HH:MM:SS
//   seg_err, sel_err  one-cycle pulses on undecodable segments / bad select
//   stalled           select static for TIMEOUT cycles
interface seg_scan_capture_if;
    logic [5:0]  seg_sel;
    logic [6:0]  seg_ment;
    logic [23:0] snap_digits;
    logic        frame_done;
    logic        range_err;
    logic        seg_err;
    logic        sel_err;
    logic        stalled;

    modport master (
        output seg_sel, seg_ment,
        input  snap_digits, frame_done, range_err, seg_err, sel_err, stalled
    );

    modport slave (
        input  seg_sel, seg_ment,
        output snap_digits, frame_done, range_err, seg_err, sel_err, stalled
    );
endinterface

// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - decodes a scanned 6-digit 7-segment bus into a time snapshot
//
// Ports:
//   clk    system clock (same domain as the scan driver)
//   rst_n  asynchronous active-low reset
//   bus    seg_scan_capture_if.slave: seg_sel/seg_ment in, snapshot and status out
// Parameters:
//   SETTLE  stable-select cycles before sampling (>= 3 to cover segment lag)
//   TIMEOUT static-select cycles before stalled is raised
module seg_scan_capture #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 400_000
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_capture_if.slave  bus
);
    localparam int SCW = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam int STW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_SAMPLE} state_t;

    state_t          state, state_nx;
    logic [5:0]      sel_q, sel_prev;
    logic [6:0]      seg_q;
    logic [SCW-1:0]  settle_cnt, settle_cnt_nx;
    logic [STW-1:0]  stall_cnt;
    logic [5:0][3:0] work, work_cap;
    logic [5:0]      seen, seen_cap;
    logic [23:0]     snap_q;
    logic            frame_q, range_q, seg_err_q, sel_err_q;
    logic            sel_chg, do_sample, sel_ok, dec_ok;
    logic [2:0]      pos;
    logic [3:0]      dec_digit;
    logic [6:0]      hours;
    logic            range_cap;

    // sel_prev holds the select value that has been settling, so during
    // SAMPLE it still names the settled position even if sel_q moved on.
    assign sel_chg = (sel_q != sel_prev);

    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        unique case (p)
            7'h01:   seg_decode = {1'b1, 4'd0};
            7'h4F:   seg_decode = {1'b1, 4'd1};
            7'h12:   seg_decode = {1'b1, 4'd2};
            7'h06:   seg_decode = {1'b1, 4'd3};
            7'h4C:   seg_decode = {1'b1, 4'd4};
            7'h24:   seg_decode = {1'b1, 4'd5};
            7'h20:   seg_decode = {1'b1, 4'd6};
            7'h0F:   seg_decode = {1'b1, 4'd7};
            7'h00:   seg_decode = {1'b1, 4'd8};
            7'h04:   seg_decode = {1'b1, 4'd9};
            default: seg_decode = 5'd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Idle bus value, so leaving reset with a blank bus is not a change.
            sel_q    <= 6'h3F;
            sel_prev <= 6'h3F;
            seg_q    <= 7'h7F;
        end else begin
            sel_q    <= bus.seg_sel;
            sel_prev <= sel_q;
            seg_q    <= bus.seg_ment;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_WAIT;
            settle_cnt <= '0;
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_cnt_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        settle_cnt_nx = settle_cnt;
        do_sample     = 1'b0;
        unique case (state)
            S_WAIT: begin
                if (sel_chg) begin
                    state_nx      = S_SETTLE;
                    settle_cnt_nx = '0;
                end
            end
            S_SETTLE: begin
                if (sel_chg) begin
                    settle_cnt_nx = '0;
                end else if (settle_cnt == SCW'(SETTLE - 1)) begin
                    state_nx = S_SAMPLE;
                end else begin
                    settle_cnt_nx = settle_cnt + 1'b1;
                end
            end
            S_SAMPLE: begin
                do_sample = 1'b1;
                if (sel_chg) begin
                    state_nx      = S_SETTLE;
                    settle_cnt_nx = '0;
                end else begin
                    state_nx = S_WAIT;
                end
            end
            default: state_nx = S_WAIT;
        endcase
    end

    // Legal select has exactly one low bit; pos is its index.
    always_comb begin
        sel_ok = 1'b0;
        pos    = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (sel_prev == ~(6'd1 << i)) begin
                sel_ok = 1'b1;
                pos    = 3'(i);
            end
        end
    end

    always_comb begin
        {dec_ok, dec_digit} = seg_decode(seg_q);
        work_cap            = work;
        work_cap[pos]       = dec_digit;
        seen_cap            = seen | (6'd1 << pos);
        hours               = {3'd0, work_cap[1]} * 7'd10 + {3'd0, work_cap[0]};
        range_cap           = (work_cap[1] > 4'd2) || (hours > 7'd23) ||
                              (work_cap[3] > 4'd5) || (work_cap[5] > 4'd5);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work      <= '0;
            seen      <= '0;
            snap_q    <= '0;
            range_q   <= 1'b0;
            frame_q   <= 1'b0;
            seg_err_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            frame_q   <= 1'b0;
            seg_err_q <= 1'b0;
            sel_err_q <= 1'b0;
            if (do_sample) begin
                if (!sel_ok) begin
                    sel_err_q <= 1'b1;
                end else if (!dec_ok) begin
                    seg_err_q <= 1'b1;
                    seen      <= '0;
                end else begin
                    work <= work_cap;
                    if (&seen_cap) begin
                        snap_q  <= work_cap;
                        range_q <= range_cap;
                        frame_q <= 1'b1;
                        seen    <= '0;
                    end else begin
                        seen <= seen_cap;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (sel_chg) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STW'(TIMEOUT)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.snap_digits = snap_q;
    assign bus.frame_done  = frame_q;
    assign bus.range_err   = range_q;
    assign bus.seg_err     = seg_err_q;
    assign bus.sel_err     = sel_err_q;
    assign bus.stalled     = (stall_cnt == STW'(TIMEOUT));
endmodule
